// File: rtl/step_pkg.sv
// rtl/step_pkg.sv - shared FSM state encoding and direction constants for step_ctrl
package step_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        HOLD_WAIT = 2'd1,
        REPEAT    = 2'd2,
        LOCKOUT   = 2'd3
    } step_state_t;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/step_ctrl_debounce.sv
// rtl/step_ctrl_debounce.sv - two-flop synchronizer plus counting debouncer for one pushbutton
module debounce #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic CLK,
    input  logic RST,
    input  logic btn,
    output logic level
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // Bring the raw asynchronous button into the CLK domain.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    // Count consecutive disagreeing samples; flip the level on the last one, clear on any agreement.
    // The counter never passes CNT_LAST, so it cannot wrap.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (sync2 == level) begin
            cnt <= '0;
        end else if (cnt >= CNT_LAST) begin
            level <= ~level;
            cnt   <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/step_ctrl.sv
// rtl/step_ctrl.sv - up/down pushbutton stepper with debounce, auto-repeat and dual-press lockout
module step_ctrl
    import step_pkg::*;
#(
    parameter int DEB_CYCLES   = 500000,
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 5000000
) (
    input  logic CLK,
    input  logic RST,
    input  logic UP_BTN,
    input  logic DN_BTN,
    output logic STEP,
    output logic DIR,
    output logic HELD
);

    localparam int DW = $clog2(REPEAT_DELAY + 1);
    localparam int RW = $clog2(REPEAT_RATE + 1);
    localparam logic [DW-1:0] DLY_LAST  = DW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST = RW'(REPEAT_RATE - 1);

    logic          up_lvl;
    logic          dn_lvl;
    logic          up_prev;
    logic          dn_prev;
    logic          up_rise;
    logic          dn_rise;
    logic          active;

    step_state_t   state;
    step_state_t   state_nx;
    logic          step_q;
    logic          step_nx;
    logic          dir_q;
    logic          dir_nx;
    logic          held_q;
    logic [DW-1:0] dly_cnt;
    logic [DW-1:0] dly_nx;
    logic [RW-1:0] rate_cnt;
    logic [RW-1:0] rate_nx;

    debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
        .CLK   (CLK),
        .RST   (RST),
        .btn   (UP_BTN),
        .level (up_lvl)
    );

    debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dn (
        .CLK   (CLK),
        .RST   (RST),
        .btn   (DN_BTN),
        .level (dn_lvl)
    );

    assign up_rise = up_lvl & ~up_prev;
    assign dn_rise = dn_lvl & ~dn_prev;
    // The button that started the current hold is identified by the latched direction.
    assign active  = (dir_q == DIR_DN) ? dn_lvl : up_lvl;

    // Next-state and next-output logic; dual press overrides everything, release overrides repeat.
    always_comb begin
        state_nx = state;
        step_nx  = 1'b0;
        dir_nx   = dir_q;
        dly_nx   = dly_cnt;
        rate_nx  = rate_cnt;
        if (up_lvl && dn_lvl) begin
            state_nx = LOCKOUT;
        end else begin
            case (state)
                IDLE: begin
                    if (up_rise ^ dn_rise) begin
                        step_nx  = 1'b1;
                        dir_nx   = dn_rise ? DIR_DN : DIR_UP;
                        dly_nx   = '0;
                        state_nx = HOLD_WAIT;
                    end
                end
                HOLD_WAIT: begin
                    if (!active) begin
                        state_nx = IDLE;
                    end else if (dly_cnt >= DLY_LAST && !step_q) begin
                        step_nx  = 1'b1;
                        rate_nx  = '0;
                        state_nx = REPEAT;
                    end else if (dly_cnt < DLY_LAST) begin
                        dly_nx = dly_cnt + 1'b1;
                    end
                end
                REPEAT: begin
                    if (!active) begin
                        state_nx = IDLE;
                    end else if (rate_cnt >= RATE_LAST && !step_q) begin
                        step_nx = 1'b1;
                        rate_nx = '0;
                    end else if (rate_cnt < RATE_LAST) begin
                        rate_nx = rate_cnt + 1'b1;
                    end
                end
                LOCKOUT: begin
                    if (!up_lvl && !dn_lvl) begin
                        state_nx = IDLE;
                    end
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
    end

    // State, counters and registered outputs; HELD reflects the state held during the previous cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            step_q   <= 1'b0;
            dir_q    <= DIR_UP;
            held_q   <= 1'b0;
            dly_cnt  <= '0;
            rate_cnt <= '0;
            up_prev  <= 1'b0;
            dn_prev  <= 1'b0;
        end else begin
            state    <= state_nx;
            step_q   <= step_nx;
            dir_q    <= dir_nx;
            held_q   <= (state == HOLD_WAIT) || (state == REPEAT);
            dly_cnt  <= dly_nx;
            rate_cnt <= rate_nx;
            up_prev  <= up_lvl;
            dn_prev  <= dn_lvl;
        end
    end

    assign STEP = step_q;
    assign DIR  = dir_q;
    assign HELD = held_q;

endmodule

// File: doc/step_ctrl.md
STEP_CTRL -- requirements
Module: step_ctrl

Interface
REQ-001 Parameter DEB_CYCLES, default 500000: consecutive stable samples required to accept a button change.
REQ-002 Parameter REPEAT_DELAY, default 25000000: hold cycles from first STEP to first auto-repeat STEP.
REQ-003 Parameter REPEAT_RATE, default 5000000: cycles between successive auto-repeat STEPs.
REQ-004 CLK  input  1  system clock; all state updates on rising edge only.
REQ-005 RST  input  1  reset, synchronous, active-high.
REQ-006 UP_BTN  input  1  raw asynchronous count-up pushbutton, active-high.
REQ-007 DN_BTN  input  1  raw asynchronous count-down pushbutton, active-high.
REQ-008 STEP  output  1  one-cycle pulse; drives the counter's enable input.
REQ-009 DIR  output  1  0 = up, 1 = down; drives the counter's REV input; valid whenever STEP is high.
REQ-010 HELD  output  1  high while the FSM is in HOLD_WAIT or REPEAT.

Function
REQ-011 Each raw button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-012 Each debouncer SHALL toggle its stable level on the edge at which the synchronized input has differed from the stable level for DEB_CYCLES consecutive cycles; any agreeing sample clears its counter.
REQ-013 Counter widths SHALL be $clog2(parameter+1); counters SHALL saturate, never wrap.
REQ-014 FSM states SHALL be IDLE, HOLD_WAIT, REPEAT, LOCKOUT.
REQ-015 IDLE: exactly one debounced button rising -> STEP=1 for one cycle, DIR set, go HOLD_WAIT with delay counter cleared.
REQ-016 HOLD_WAIT: pressed button still high and delay counter reaches REPEAT_DELAY-1 -> STEP pulse, go REPEAT with rate counter cleared.
REQ-017 REPEAT: rate counter reaches REPEAT_RATE-1 -> STEP pulse, rate counter cleared, remain in REPEAT.
REQ-018 HOLD_WAIT/REPEAT: active button released -> IDLE, no STEP that cycle.
REQ-019 Any state: both debounced buttons high -> LOCKOUT, no STEP; LOCKOUT exits to IDLE only when both are low.
REQ-020 Both debounced buttons rising in the same cycle from IDLE -> LOCKOUT, no STEP.
REQ-021 DIR SHALL change only in a cycle where STEP is asserted and hold its value otherwise.
REQ-022 STEP SHALL never be high in two consecutive cycles.
REQ-023 Latency: raw UP_BTN high from before edge 0 and held -> STEP high in the cycle after edge DEB_CYCLES+2.

Reset
REQ-024 RST high at a clock edge SHALL clear synchronizers, debounce counters, stable levels, FSM (IDLE), STEP=0, DIR=0, HELD=0.
REQ-025 RST SHALL take precedence over all other inputs, including mid-repeat; a button held through reset release SHALL produce a STEP only after re-debouncing (REQ-023 latency from reset release).

Structure
REQ-026 Shared package step_pkg SHALL hold the FSM state enum and DIR_UP/DIR_DN constants.
REQ-027 Sub-module debounce (synchronizer + counter + stable level, parameter DEB_CYCLES) SHALL be instantiated twice.

Verification (bench parameters DEB_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=8)
REQ-028 UP_BTN held from cycle 0 -> STEP high only in cycle 7, DIR=0, HELD=1 from cycle 8.
REQ-029 DN_BTN held 60 cycles -> STEPs at cycles 7, 27, 35, 43, 51, 59, DIR=1 on each.
REQ-030 UP_BTN glitched high 3 cycles, then low -> no STEP, FSM stays IDLE.
REQ-031 UP held, DN pressed at cycle 15 -> no STEP after cycle 7, LOCKOUT; both released -> IDLE; next UP press steps normally.
REQ-032 RST pulsed at cycle 30 during DN repeat with DN still held -> STEP=0 cycles 30-37, next STEP at cycle 38 (RST deasserted at 31).
REQ-033 Counter-output checker: feed STEP/DIR into the 4-bit counter, 17 up steps from 0 -> count 1 (wrap via 15->0).
